// File: rtl/bram_arbiter_if.sv
// rtl/bram_arbiter_if.sv - requester A/B command and response channels plus BRAM port bundle
interface bram_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  a_valid;
  logic                  a_ready;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_rsp_valid;
  logic [DATA_WIDTH-1:0] a_rsp_data;

  logic                  b_valid;
  logic                  b_ready;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_rsp_valid;
  logic [DATA_WIDTH-1:0] b_rsp_data;

  logic                  bram_write_enable;
  logic                  bram_read_enable;
  logic [ADDR_WIDTH-1:0] bram_address;
  logic [DATA_WIDTH-1:0] bram_data_in;
  logic [DATA_WIDTH-1:0] bram_data_out;

  // Client engines and the BRAM instance together form the master side.
  modport master (
    output a_valid, a_we, a_addr, a_wdata,
    input  a_ready, a_rsp_valid, a_rsp_data,
    output b_valid, b_we, b_addr, b_wdata,
    input  b_ready, b_rsp_valid, b_rsp_data,
    input  bram_write_enable, bram_read_enable, bram_address, bram_data_in,
    output bram_data_out
  );

  // The arbiter is the slave side.
  modport slave (
    input  a_valid, a_we, a_addr, a_wdata,
    output a_ready, a_rsp_valid, a_rsp_data,
    input  b_valid, b_we, b_addr, b_wdata,
    output b_ready, b_rsp_valid, b_rsp_data,
    output bram_write_enable, bram_read_enable, bram_address, bram_data_in,
    input  bram_data_out
  );
endinterface

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - round-robin two-requester arbiter for a single-port BRAM
module bram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  bram_arbiter_if.slave        bus,
  output logic [CNT_WIDTH-1:0] grant_cnt_a,
  output logic [CNT_WIDTH-1:0] grant_cnt_b
);
  // last_grant_b = 1 means B won the most recent transfer, so A wins the next conflict.
  logic                  last_grant_b;
  logic                  rsp_pending;
  logic                  rsp_owner_b;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  grant_a;
  logic                  grant_b;
  logic                  grant_any;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  // Pick the winner for this cycle; ready doubles as the grant since it only rises with valid.
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    win_we    = 1'b0;
    win_addr  = addr_q;
    win_wdata = data_q;
    if (!rst) begin
      grant_a = bus.a_valid && (!bus.b_valid || last_grant_b);
      grant_b = bus.b_valid && !grant_a;
    end
    if (grant_a) begin
      win_we    = bus.a_we;
      win_addr  = bus.a_addr;
      win_wdata = bus.a_wdata;
    end else if (grant_b) begin
      win_we    = bus.b_we;
      win_addr  = bus.b_addr;
      win_wdata = bus.b_wdata;
    end
    grant_any = grant_a || grant_b;
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  // Enables are mutually exclusive by construction; address/data hold their last driven value when idle.
  assign bus.bram_write_enable = grant_any && win_we;
  assign bus.bram_read_enable  = grant_any && !win_we;
  assign bus.bram_address      = win_addr;
  assign bus.bram_data_in      = (grant_any && win_we) ? win_wdata : data_q;

  // Read data is shared; only the owner's valid qualifies it. Reset drops an in-flight response.
  assign bus.a_rsp_valid = rsp_pending && !rsp_owner_b && !rst;
  assign bus.b_rsp_valid = rsp_pending && rsp_owner_b && !rst;
  assign bus.a_rsp_data  = bus.bram_data_out;
  assign bus.b_rsp_data  = bus.bram_data_out;

  // Round-robin pointer and response tracking, updated only on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_b <= 1'b1;
      rsp_pending  <= 1'b0;
      rsp_owner_b  <= 1'b0;
    end else begin
      rsp_pending <= grant_any && !win_we;
      if (grant_any) begin
        last_grant_b <= grant_b;
        rsp_owner_b  <= grant_b;
      end
    end
  end

  // Remember the last address and write data so an idle BRAM port stays quiet.
  always_ff @(posedge clk) begin
    if (grant_any) begin
      addr_q <= win_addr;
    end
    if (grant_any && win_we) begin
      data_q <= win_wdata;
    end
  end

  // Per-requester accepted-command counters, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_a <= '0;
      grant_cnt_b <= '0;
    end else begin
      if (grant_a && (grant_cnt_a != '1)) begin
        grant_cnt_a <= grant_cnt_a + 1'b1;
      end
      if (grant_b && (grant_cnt_b != '1)) begin
        grant_cnt_b <= grant_cnt_b + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - self-checking bench for bram_arbiter against a behavioural model
module tb_bram_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_s;
  logic [CW-1:0] cnt_a, cnt_b;
  logic [1:0]    scnt_a, scnt_b;

  bram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  bram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) sbus ();

  bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_cnt_a(cnt_a), .grant_cnt_b(cnt_b)
  );

  bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst_s), .bus(sbus), .grant_cnt_a(scnt_a), .grant_cnt_b(scnt_b)
  );

  // BRAM: synchronous read, one cycle of latency.
  logic [DW-1:0] bram_mem [2**AW];
  always @(posedge clk) begin
    if (bus.bram_write_enable) bram_mem[bus.bram_address] <= bus.bram_data_in;
    if (bus.bram_read_enable)  bus.bram_data_out <= bram_mem[bus.bram_address];
  end
  assign sbus.bram_data_out = '0;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit            m_last_b;
  bit            m_pend;
  bit            m_owner_b;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_mem [2**AW];
  int            m_cnt_a, m_cnt_b;
  bit            m_addr_ok, m_din_ok;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the commands, compare against the model mid-cycle, then advance the model.
  task automatic cycle(input bit r,
                       input bit av, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit bv, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       output int win);
    bit            e_we, e_re;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    rst = r;
    bus.a_valid = av; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
    bus.b_valid = bv; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
    @(negedge clk);
    if (r)              win = 0;
    else if (av && bv)  win = m_last_b ? 1 : 2;
    else if (av)        win = 1;
    else if (bv)        win = 2;
    else                win = 0;
    e_we   = (win == 1) ? aw : (win == 2) ? bw : 1'b0;
    e_re   = (win != 0) && !e_we;
    e_addr = (win == 1) ? aa : ba;
    e_wd   = (win == 1) ? ad : bd;
    check("a_ready", bus.a_ready, win == 1);
    check("b_ready", bus.b_ready, win == 2);
    check("write_enable", bus.bram_write_enable, e_we);
    check("read_enable", bus.bram_read_enable, e_re);
    if (win != 0) begin
      check("address", bus.bram_address, e_addr);
      m_addr = e_addr; m_addr_ok = 1;
    end else if (m_addr_ok) begin
      check("address_hold", bus.bram_address, m_addr);
    end
    if (e_we) begin
      check("data_in", bus.bram_data_in, e_wd);
      m_din = e_wd; m_din_ok = 1;
    end else if (m_din_ok) begin
      check("data_in_hold", bus.bram_data_in, m_din);
    end
    check("a_rsp_valid", bus.a_rsp_valid, !r && m_pend && !m_owner_b);
    check("b_rsp_valid", bus.b_rsp_valid, !r && m_pend && m_owner_b);
    if (!r && m_pend) begin
      if (m_owner_b) check("b_rsp_data", bus.b_rsp_data, m_rdata);
      else           check("a_rsp_data", bus.a_rsp_data, m_rdata);
    end
    check("grant_cnt_a", cnt_a, m_cnt_a);
    check("grant_cnt_b", cnt_b, m_cnt_b);
    if (r) begin
      m_last_b = 1; m_pend = 0; m_cnt_a = 0; m_cnt_b = 0;
    end else begin
      m_pend = 0;
      if (win != 0) begin
        m_last_b = (win == 2);
        if (win == 1 && m_cnt_a < 2**CW - 1) m_cnt_a++;
        if (win == 2 && m_cnt_b < 2**CW - 1) m_cnt_b++;
        if (e_we) m_mem[e_addr] = e_wd;
        else begin
          m_pend = 1; m_owner_b = (win == 2); m_rdata = m_mem[e_addr];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    bit ha, hb;
    bit av, aw, bv, bw;
    logic [AW-1:0] aa, ba;
    logic [DW-1:0] ad, bd;
    int base_a, base_b;

    rst = 1; rst_s = 1;
    bus.a_valid = 0; bus.b_valid = 0; bus.a_we = 0; bus.b_we = 0;
    bus.a_addr = 0; bus.b_addr = 0; bus.a_wdata = 0; bus.b_wdata = 0;
    sbus.a_valid = 0; sbus.b_valid = 0; sbus.a_we = 0; sbus.b_we = 0;
    sbus.a_addr = 0; sbus.b_addr = 0; sbus.a_wdata = 0; sbus.b_wdata = 0;
    m_last_b = 1; m_pend = 0; m_owner_b = 0; m_rdata = '0;
    m_cnt_a = 0; m_cnt_b = 0; m_addr_ok = 0; m_din_ok = 0; m_addr = '0; m_din = '0;
    for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
    @(posedge clk); #1;

    // Reset held two cycles with both requesters valid; then the first conflict goes to A.
    cycle(1, 1, 1, 4'd0, 8'h00, 1, 1, 4'd0, 8'h00, w);
    cycle(1, 1, 1, 4'd0, 8'h00, 1, 1, 4'd0, 8'h00, w);
    cycle(0, 1, 1, 4'd0, 8'h00, 1, 1, 4'd0, 8'h00, w);
    cycle(0, 0, 0, 4'd0, 8'h00, 1, 1, 4'd0, 8'h00, w);
    cycle(1, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, w);

    // Single requester: A fills the memory then reads it all back.
    for (int i = 0; i < 16; i++) cycle(0, 1, 1, 4'(i), 8'(i + 1), 0, 0, 4'd0, 8'h00, w);
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, 4'(i), 8'h00, 0, 0, 4'd0, 8'h00, w);
    check("single_last_rsp_data", bus.a_rsp_data, 32'h10);
    cycle(0, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, w);
    check("single_cnt_a", cnt_a, 32);
    check("single_cnt_b", cnt_b, 0);

    // Contention: both hold valid for 8 cycles and must alternate.
    base_a = m_cnt_a; base_b = m_cnt_b;
    for (int i = 0; i < 8; i++) begin
      if (w == 1 || i == 0) cycle(0, 1, 1, 4'($urandom), 8'($urandom), 1, 1, 4'($urandom), 8'($urandom), w);
      else                  cycle(0, 1, 1, 4'($urandom), 8'($urandom), 1, 1, 4'($urandom), 8'($urandom), w);
    end
    check("contend_cnt_a", cnt_a, 32 + 4);
    check("contend_cnt_b", cnt_b, 4);

    // Preload addr = data + 1, then A reads 3 and B reads 12 back to back.
    for (int i = 0; i < 16; i++) cycle(0, 1, 1, 4'(i), 8'(i + 1), 0, 0, 4'd0, 8'h00, w);
    cycle(0, 1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00, w);
    check("route_a_valid", bus.a_rsp_valid, 1);
    check("route_a_data", bus.a_rsp_data, 32'h04);
    cycle(0, 0, 0, 4'd0, 8'h00, 1, 0, 4'd12, 8'h00, w);
    check("route_b_valid", bus.b_rsp_valid, 1);
    check("route_b_data", bus.b_rsp_data, 32'h0D);
    check("route_a_one_cycle", bus.a_rsp_valid, 0);
    cycle(0, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, w);
    check("route_b_one_cycle", bus.b_rsp_valid, 0);

    // Write by A then read of the same address by B on the next cycle.
    cycle(0, 1, 1, 4'd5, 8'hAA, 0, 0, 4'd0, 8'h00, w);
    cycle(0, 0, 0, 4'd0, 8'h00, 1, 0, 4'd5, 8'h00, w);
    check("hazard_b_data", bus.b_rsp_data, 32'hAA);
    cycle(0, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, w);

    // Reset lands on the cycle after a B read grant; the response must be dropped.
    cycle(0, 0, 0, 4'd0, 8'h00, 1, 0, 4'd1, 8'h00, w);
    cycle(1, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, w);
    check("rst_drop_b_valid", bus.b_rsp_valid, 0);
    cycle(0, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, w);

    // Random traffic; a requester that loses keeps its command stable until accepted.
    ha = 0; hb = 0;
    av = 0; aw = 0; aa = '0; ad = '0; bv = 0; bw = 0; ba = '0; bd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!ha) begin
        av = ($urandom_range(0, 3) != 0); aw = $urandom_range(0, 1) == 1;
        aa = 4'($urandom); ad = 8'($urandom);
      end
      if (!hb) begin
        bv = ($urandom_range(0, 3) != 0); bw = $urandom_range(0, 1) == 1;
        ba = 4'($urandom); bd = 8'($urandom);
      end
      cycle(0, av, aw, aa, ad, bv, bw, ba, bd, w);
      ha = av && (w != 1);
      hb = bv && (w != 2);
    end
    cycle(0, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, w);

    // Saturation with a 2-bit counter: 5 transfers stop at 3.
    rst_s = 1;
    @(posedge clk); #1;
    rst_s = 0;
    check("sat_reset_cnt_a", scnt_a, 0);
    sbus.a_valid = 1; sbus.a_we = 1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check("sat_cnt_a", scnt_a, (k < 3) ? k : 3);
    end
    sbus.a_valid = 0;
    check("sat_cnt_b", scnt_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Two-requester arbiter sharing one single-port BRAM (DATA_WIDTH x 2^ADDR_WIDTH, synchronous read, 1-cycle latency).
- Each requester has a valid/ready command channel and a read-response channel.
- Grants at most one BRAM access per cycle, round-robin, and returns read data to the originating requester.
- Sits between two client engines (e.g. a loader and a checker) and the BRAM instance.

Parameters:
- DATA_WIDTH, 8, BRAM word width.
- ADDR_WIDTH, 4, BRAM address width (depth 2^ADDR_WIDTH).
- CNT_WIDTH, 16, width of the per-requester grant counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- a_valid  in  1  requester A command valid.
- a_ready  out  1  requester A command accepted this cycle.
- a_we  in  1  A command type: 1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  A address.
- a_wdata  in  DATA_WIDTH  A write data.
- a_rsp_valid  out  1  A read data valid.
- a_rsp_data  out  DATA_WIDTH  A read data.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rsp_valid, b_rsp_data: same as the A set, for requester B.
- bram_write_enable  out  1  to BRAM write_enable.
- bram_read_enable  out  1  to BRAM read_enable.
- bram_address  out  ADDR_WIDTH  to BRAM address.
- bram_data_in  out  DATA_WIDTH  to BRAM data_in.
- bram_data_out  in  DATA_WIDTH  from BRAM data_out; valid the cycle after the read enable is sampled.
- grant_cnt_a  out  CNT_WIDTH  number of A commands accepted, saturating.
- grant_cnt_b  out  CNT_WIDTH  number of B commands accepted, saturating.

Behaviour:
- Reset (clk edge with rst=1):
  - last_grant <= B, so A wins the first conflict.
  - rsp_pending <= 0; a_rsp_valid, b_rsp_valid <= 0.
  - grant_cnt_a, grant_cnt_b <= 0.
  - While rst=1: a_ready = b_ready = 0 and bram_write_enable = bram_read_enable = 0.
- Arbitration (combinational within the cycle; rst=0):
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the requester that is not last_grant.
  - No valid -> no grant; all BRAM enables 0.
  - x_ready = 1 only for the granted requester. A command transfers when x_valid & x_ready.
  - last_grant updates to the winner only on a transfer. Idle cycles leave it unchanged.
- BRAM drive:
  - Granted write: bram_write_enable=1, bram_read_enable=0, address and data_in from the winner.
  - Granted read: bram_read_enable=1, bram_write_enable=0, address from the winner.
  - No grant: address and data_in hold their previous values; enables are 0.
  - Write and read enables are never both 1.
- Response path:
  - A read granted in cycle N registers rsp_owner and rsp_pending.
  - In cycle N+1: owner's x_rsp_valid=1 for exactly one cycle, and x_rsp_data = bram_data_out.
  - The non-owner's rsp_valid=0. Its rsp_data is don't-care (drive bram_data_out to both).
  - Writes produce no response.
  - Back-to-back reads, including alternating A/B, give one response per cycle in grant order.
- Throughput: one command per cycle sustained; no bubbles between consecutive grants.
- Counters:
  - grant_cnt_x increments on each x transfer.
  - Holds at 2^CNT_WIDTH-1 (no wrap).
- Boundary cases:
  - Requester drops valid while not granted: legal, nothing recorded.
  - Requester holding valid but losing arbitration must hold its command stable until ready.
  - Same address written by A and read by B in consecutive cycles: B sees A's data (write committed first).
  - Address wrap is not an arbiter concern; addresses pass through unmodified.
  - rst asserted while a read is in flight: the response is dropped, and rsp_valid is 0 in the following cycle.

Test Plan:
- Reset: rst=1 for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, enables 0, counters 0; after rst drops, first conflict grants A.
- Single requester: A writes 0x01..0x10 to addr 0..15, then reads addr 0..15 -> 16 a_rsp_valid pulses, each one cycle after its grant, data 0x01..0x10; b_rsp_valid stays 0; grant_cnt_a=32.
- Contention: A and B both hold valid for 8 cycles -> grants strictly alternate A,B,A,B...; grant_cnt_a=4, grant_cnt_b=4; no cycle has both ready high.
- Interleaved read routing: A reads addr 3 and B reads addr 12 back-to-back after a preload of addr=data+1 -> a_rsp_data=0x04, then b_rsp_data=0x0D on the next cycle; each valid lasts one cycle.
- Write-then-read hazard: A writes 0xAA to addr 5 in cycle N, B reads addr 5 in cycle N+1 -> b_rsp_data=0xAA in cycle N+2.
- Reset mid-read plus saturation: rst asserted the cycle after a B read grant -> b_rsp_valid=0 next cycle. Separately, CNT_WIDTH=2 with 5 A transfers -> grant_cnt_a=3.
